y86_fetch_aligner: RTL and testbench
====================================

// Module: y86_fetch_aligner
// PURPOSE
//  Instruction fetch/align stage fed by the PC register. Prefetches aligned 32-bit words
//  from instruction memory into a byte queue and presents one complete variable-length
//  Y86 instruction (1-6 bytes) per handshake to decode. Supports redirect (jump/call/ret)
//  to any byte address, flushing queued bytes and discarding in-flight data.
// PARAMETERS
//  RESET_PC   32'h0  byte address of first instruction after reset
//  BUF_BYTES  8      byte-queue capacity; legal range 8..16
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch byte address
//  imem_req     out  1   word read request
//  imem_addr    out  32  word address, bits [1:0] always 0
//  imem_ack     in   1   transfer when imem_req && imem_ack (same-cycle ack legal)
//  imem_rdata   in   32  read data, little-endian (byte at addr+0 in [7:0])
//  inst_valid   out  1   complete instruction present at head of queue
//  inst_ready   in   1   decode accepts; fire = inst_valid && inst_ready
//  inst_bytes   out  48  instruction bytes, byte0 in [7:0]; unused high bytes = 0
//  inst_len     out  3   length 1..6
//  inst_pc      out  32  byte address of byte0
//  inst_err     out  1   icode invalid (byte0[7:4] > 4'hB)
// BEHAVIOUR
//  - Reset: queue empty, head pc=RESET_PC, fetch addr=RESET_PC&~3, skip=RESET_PC[1:0],
//    drop=0; imem_req=0, inst_valid=0, inst_bytes=0, inst_len=1, inst_err=0. Reset
//    mid-request abandons it; ack with no request pending is ignored.
//  - Length from icode=byte0[7:4]: 0,1,9->1; 2,6,A,B->2; 7,8->5; 3,4,5->6; C..F->1 with
//    inst_err=1 (decode raises the exception; aligner keeps fetching).
//  - inst_valid = (count>=1) && (count>=inst_len) && !redirect. Outputs combinational
//    from queue head; fire pops inst_len bytes and adds inst_len to head pc (mod 2^32).
//  - Request issue: imem_req rises when no request pending and free bytes
//    (BUF_BYTES-count) >= 4; imem_req, imem_addr held stable until ack.
//  - On transfer: if drop=1, data discarded, drop cleared. Else bytes [skip..3] pushed in
//    address order, skip cleared to 0, fetch addr += 4 (wraps). Push and pop in same
//    cycle both apply; count updates by pushed - popped.
//  - Redirect (cycle T): queue cleared, head pc=redirect_pc, fetch addr=redirect_pc&~3,
//    skip=redirect_pc[1:0]. If a request is pending and not acked in T, it stays asserted
//    to completion with drop=1; if acked in T, its data is discarded. No fire in T.
//    Redirect has priority over fire, push and reset-free state; reset beats redirect.
//  - Latency: redirect at T, ack-same-cycle memory -> imem_req at T+1, earliest
//    inst_valid at T+2 (short instr in first word).
//  - Full: count never exceeds BUF_BYTES; no request while free < 4.
//  - Throughput: one instruction per cycle when queue holds it; 6-byte instr needs 2 words.
// TESTING
//  1 Reset, RESET_PC=0, mem = 10 10 10 00 -> imem_addr 0x0; three fires len1 pc 0,1,2
//    (nop), then halt len1 pc 3, inst_err=0.
//  2 irmovl at 0x4: 30 F3 78 56 34 12 -> inst_len 6, inst_bytes 48'h123456_78F330,
//    valid only after second word accepted, next pc 0xA.
//  3 Redirect to 0x102 (mem 0x100 = AA BB 60 12) -> imem_addr 0x100, first inst pc 0x102,
//    bytes 60 12, len 2; bytes 0xAA,0xBB never presented.
//  4 inst_ready=0, stream of nops -> count reaches 8, imem_req stays 0; release ready ->
//    one fire/cycle, new request once free>=4.
//  5 Memory ack delayed 3 cycles, redirect to 0x40 during pending -> first ack's data
//    dropped, next imem_addr 0x40, first inst_pc 0x40.
//  6 byte0=F0 -> inst_err=1, inst_len 1, next instr at pc+1; reset asserted mid-request ->
//    imem_req=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/y86_fetch_aligner.sv
// Fetches aligned words into a byte queue and presents one whole Y86 instruction per handshake.
// Redirect to first request is 1 cycle; decode backpressure holds the head, and fetch pauses while fewer than 4 bytes are free.
module y86_fetch_aligner #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [47:0] inst_bytes,
    output logic [2:0]  inst_len,
    output logic [31:0] inst_pc,
    output logic        inst_err
);
    localparam int QW = 8 * BUF_BYTES;

    // Bytes at or above count are kept zero, so pushes can be OR-ed in place.
    logic [QW-1:0] q, q_shift, q_ins, q_n;
    logic [4:0]    count, base, count_n;
    logic [31:0]   head_pc, fetch_addr, fetch_n, req_addr;
    logic [1:0]    skip, skip_n;
    logic          req, drop, drop_n;
    logic [2:0]    len, pop, push_cnt;
    logic [3:0]    icode;
    logic          fire, xfer, push_en, issue;

    assign icode = q[7:4];

    always_comb begin
        case (icode)
            4'h0, 4'h1, 4'h9:       len = 3'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 3'd2;
            4'h7, 4'h8:             len = 3'd5;
            4'h3, 4'h4, 4'h5:       len = 3'd6;
            default:                len = 3'd1;
        endcase
    end

    assign inst_len   = len;
    assign inst_err   = icode > 4'hB;
    assign inst_pc    = head_pc;
    assign inst_valid = (count != 5'd0) && (count >= {2'b00, len}) && !redirect;
    assign inst_bytes = q[47:0] & ~(48'hFFFF_FFFF_FFFF << {len, 3'b000});

    assign imem_req  = req;
    assign imem_addr = req_addr;

    assign fire     = inst_valid && inst_ready;
    assign pop      = fire ? len : 3'd0;
    assign xfer     = req && imem_ack;
    assign push_en  = xfer && !drop && !redirect;
    assign push_cnt = 3'd4 - {1'b0, skip};

    always_comb begin
        q_shift = q >> {pop, 3'b000};
        base    = count - {2'b00, pop};
        q_ins   = push_en ? (QW'(imem_rdata >> {skip, 3'b000}) << {base, 3'b000}) : '0;
        if (redirect) begin
            q_n     = '0;
            count_n = 5'd0;
            fetch_n = {redirect_pc[31:2], 2'b00};
            skip_n  = redirect_pc[1:0];
            drop_n  = req && !imem_ack;
        end else begin
            q_n     = q_shift | q_ins;
            count_n = push_en ? base + {2'b00, push_cnt} : base;
            fetch_n = push_en ? fetch_addr + 32'd4 : fetch_addr;
            skip_n  = push_en ? 2'b00 : skip;
            drop_n  = xfer ? 1'b0 : drop;
        end
        // A pending request is never re-issued; a new one needs room for a full word.
        issue = !(req && !imem_ack) && (({1'b0, count_n} + 6'd4) <= 6'(BUF_BYTES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            count      <= 5'd0;
            head_pc    <= RESET_PC;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            req_addr   <= {RESET_PC[31:2], 2'b00};
            skip       <= RESET_PC[1:0];
            req        <= 1'b0;
            drop       <= 1'b0;
        end else begin
            q          <= q_n;
            count      <= count_n;
            head_pc    <= redirect ? redirect_pc : head_pc + {29'b0, pop};
            fetch_addr <= fetch_n;
            skip       <= skip_n;
            drop       <= drop_n;
            if (issue) begin
                req      <= 1'b1;
                req_addr <= fetch_n;
            end else if (xfer) begin
                req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_y86_fetch_aligner.sv
// Randomized bench for y86_fetch_aligner against a byte-stream reference of instruction memory.
module tb_y86_fetch_aligner;
    logic        clk = 1'b0;
    logic        reset, redirect, imem_req, imem_ack, inst_valid, inst_ready, inst_err;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_pc;
    logic [47:0] inst_bytes;
    logic [2:0]  inst_len;

    always #5 clk = ~clk;

    y86_fetch_aligner #(.RESET_PC(32'h0), .BUF_BYTES(8)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bytes(inst_bytes),
        .inst_len(inst_len), .inst_pc(inst_pc), .inst_err(inst_err)
    );

    logic [7:0]  mem [1024];
    int          n_chk = 0, n_fail = 0;
    int          lat_left = -1, lat_mode = 0, idle = 0, fires = 0;
    bit          prev_pend = 0, ack_seen = 0, found;
    logic [31:0] exp_pc = 32'h0, hold_addr = 32'h0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_len(input logic [7:0] b0);
        case (b0[7:4])
            4'h2, 4'h6, 4'hA, 4'hB: return 3'd2;
            4'h7, 4'h8:             return 3'd5;
            4'h3, 4'h4, 4'h5:       return 3'd6;
            default:                return 3'd1;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
    endfunction

    function automatic int pick_lat();
        if (lat_mode < 0) return int'($urandom_range(3, 0));
        return lat_mode;
    endfunction

    task automatic check_inst();
        logic [47:0] eb;
        logic [7:0]  b0;
        logic [2:0]  n;
        b0 = mem[exp_pc[9:0]];
        n  = ref_len(b0);
        eb = '0;
        for (int k = 0; k < int'(n); k++) eb[8*k +: 8] = mem[10'(exp_pc + 32'(k))];
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_len", inst_len, n);
        chk("inst_bytes", inst_bytes, eb);
        chk("inst_err", inst_err, b0[7:4] > 4'hB);
        if (exp_pc == 32'h4) chk("irmovl_bytes", inst_bytes, 48'h1234_5678_F330);
        exp_pc = exp_pc + {29'b0, n};
    endtask

    // One clock cycle: drive inputs, answer memory, check, then advance past the edge.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        reset = rst; redirect = redir; redirect_pc = rpc; inst_ready = rdy;
        if (prev_pend) chk("req_hold", {imem_req, imem_addr}, {1'b1, hold_addr});
        if (imem_req) begin
            chk("addr_align", imem_addr[1:0], 2'b00);
            if (lat_left < 0) lat_left = pick_lat();
            if (lat_left == 0) begin
                imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); lat_left = -1; ack_seen = 1;
            end else begin
                imem_ack = 1'b0; imem_rdata = $urandom; lat_left--;
            end
        end else begin
            imem_ack   = ($urandom_range(7, 0) == 0);
            imem_rdata = $urandom;
            lat_left   = -1;
        end
        #1;
        prev_pend = imem_req && !imem_ack && !rst;
        hold_addr = imem_addr;
        if (rst) begin
            exp_pc = 32'h0; idle = 0; lat_left = -1;
        end else if (redir) begin
            chk("no_fire_on_redirect", inst_valid, 1'b0);
            exp_pc = rpc; idle = 0;
        end else if (inst_valid && rdy) begin
            check_inst(); fires++; idle = 0;
        end else if (rdy) begin
            idle++;
            if (idle > 60) begin
                chk("liveness_stall", idle, 0); idle = 0;
            end
        end else begin
            idle = 0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h30; mem[5] = 8'hF3; mem[6] = 8'h78; mem[7] = 8'h56; mem[8] = 8'h34; mem[9] = 8'h12;
        mem[256] = 8'hAA; mem[257] = 8'hBB; mem[258] = 8'h60; mem[259] = 8'h12;
        for (int i = 512; i < 576; i++) mem[i] = 8'h10;
        mem[768] = 8'hF0;

        @(posedge clk); #1;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_bytes", inst_bytes, 48'h0);
        chk("rst_len", inst_len, 3'd1);
        chk("rst_err", inst_err, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);

        // nops, halt, then irmovl spanning two words
        lat_mode = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

        step(1'b0, 1'b1, 32'h102, 1'b1);
        chk("t3_req", {imem_req, imem_addr}, {1'b1, 32'h100});
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // fill with decode stalled, then drain at full rate
        step(1'b0, 1'b1, 32'h200, 1'b0);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_req_idle", imem_req, 1'b0);
        chk("t4_valid_held", inst_valid, 1'b1);
        begin
            int f0;
            f0 = fires;
            repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("t4_fire_rate", fires - f0, 8);
        end

        // redirect while a slow request is outstanding
        lat_mode = 3;
        step(1'b0, 1'b1, 32'h80, 1'b1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin found = 1; break; end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("t5_req_seen", found, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        ack_seen = 0;
        step(1'b0, 1'b1, 32'h40, 1'b1);
        found = 0;
        for (int i = 0; i < 15; i++) begin
            if (ack_seen && imem_req) begin found = 1; break; end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("t5_refetch_seen", found, 1'b1);
        chk("t5_addr", imem_addr, 32'h40);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1);

        // invalid icode, then reset during an outstanding request
        lat_mode = 1;
        step(1'b0, 1'b1, 32'h300, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
        lat_mode = 3;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && lat_left != 0) begin found = 1; break; end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("t6_pending", found, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_req_dropped", {imem_req, imem_addr}, {1'b0, 32'h0});
        lat_mode = 0;
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

        lat_mode = -1;
        repeat (3000) begin
            logic        r, d, y;
            logic [31:0] p;
            r = ($urandom_range(399, 0) == 0);
            d = ($urandom_range(29, 0) == 0);
            y = ($urandom_range(3, 0) != 0);
            p = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFF0 + $urandom_range(15, 0)
                                            : 32'($urandom_range(1023, 0));
            step(r, d, p, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
